// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO bridge: register map, CON bit layout,
// TX sequencer state encoding and the word-address decode helper.
package uart_mmio_pkg;

   localparam logic [31:0] TXD_OFF = 32'h0;
   localparam logic [31:0] RXD_OFF = 32'h4;
   localparam logic [31:0] CON_OFF = 32'h8;

   localparam int CON_RXNE   = 0;
   localparam int CON_OVR    = 1;
   localparam int CON_TXFULL = 2;
   localparam int CON_TXIDLE = 3;
   localparam int CON_RXIE   = 4;
   localparam int CON_TXIE   = 5;

   // WAIT_BUSY gives up after this many extra cycles (4 cycles in total).
   localparam logic [1:0] BUSY_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } tx_state_t;

   // Registers are word-sized; the byte offset inside the word is ignored.
   function automatic logic word_hit(logic [31:0] a, logic [31:0] reg_addr);
      return a[31:2] == reg_addr[31:2];
   endfunction

endpackage

// File: rtl/uart_mmio_bridge_if.sv
// CPU data-bus view of the bridge: single-cycle load/store qualifiers with a
// combinational read-data return.
interface uart_mmio_bridge_if;
   logic [31:0] addr;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output addr, output MemRead, output MemWrite, output wdata, input rdata);
   modport slave  (input addr, input MemRead, input MemWrite, input wdata, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with an extra pointer bit to tell full from empty.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     sysclk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign dout    = mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: empty/full come from the pointers alone.
   always_ff @(posedge sysclk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped TXD/RXD/CON front end between the CPU data bus and the UART
// send/receive wrapper, with RX/TX byte FIFOs and a level interrupt.
module uart_mmio_bridge
   import uart_mmio_pkg::*;
#(
   parameter int          RX_DEPTH  = 8,
   parameter int          TX_DEPTH  = 8,
   parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
   input  logic                 sysclk,
   input  logic                 reset_n,
   uart_mmio_bridge_if.slave    bus,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   input  logic                 tx_busy,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   output logic                 irq,
   output tx_state_t            dbg_state
);
   localparam logic [31:0] TXD_A = BASE_ADDR + TXD_OFF;
   localparam logic [31:0] RXD_A = BASE_ADDR + RXD_OFF;
   localparam logic [31:0] CON_A = BASE_ADDR + CON_OFF;

   // Handshakes: rx_valid is a one-cycle strobe with no back-pressure (bytes
   // that find the RX FIFO full are dropped and flagged as overrun); tx_start
   // is a one-cycle trigger issued only while tx_busy is low, with tx_data
   // already stable in that cycle and held until the next launch.

   logic hit_txd, hit_rxd, hit_con;
   logic txd_wr, rxd_rd, con_wr;

   assign hit_txd = word_hit(bus.addr, TXD_A);
   assign hit_rxd = word_hit(bus.addr, RXD_A);
   assign hit_con = word_hit(bus.addr, CON_A);
   assign txd_wr  = bus.MemWrite && hit_txd;
   assign rxd_rd  = bus.MemRead  && hit_rxd;
   assign con_wr  = bus.MemWrite && hit_con;

   logic [7:0]                  rx_dout, tx_dout;
   logic                        rx_full, rx_empty, tx_full, tx_empty;
   logic [$clog2(RX_DEPTH):0]   rx_count;
   logic [$clog2(TX_DEPTH):0]   tx_count;
   logic                        tx_pop;

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .sysclk  (sysclk),
      .reset_n (reset_n),
      .push    (rx_valid),
      .pop     (rxd_rd),
      .din     (rx_data),
      .dout    (rx_dout),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .sysclk  (sysclk),
      .reset_n (reset_n),
      .push    (txd_wr),
      .pop     (tx_pop),
      .din     (bus.wdata[7:0]),
      .dout    (tx_dout),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count)
   );

   tx_state_t  state, state_nx;
   logic [1:0] wait_cnt, wait_cnt_nx;
   logic       ld_data;

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
      end
   end

   // tx_data is captured on the way into LAUNCH so it is valid alongside tx_start.
   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      ld_data     = 1'b0;
      tx_pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!tx_empty && !tx_busy) begin
               state_nx = LAUNCH;
               ld_data  = 1'b1;
            end
         end
         LAUNCH: begin
            tx_pop      = 1'b1;
            wait_cnt_nx = '0;
            state_nx    = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy)                        state_nx = WAIT_DONE;
            else if (wait_cnt == BUSY_TIMEOUT)  state_nx = IDLE;
            else                                wait_cnt_nx = wait_cnt + 2'd1;
         end
         WAIT_DONE: begin
            if (!tx_busy) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign tx_start  = (state == LAUNCH);
   assign dbg_state = state;

   logic overrun, rx_irq_en, tx_irq_en, tx_idle, ovr_set, ovr_clr;

   assign tx_idle = tx_empty && (state == IDLE) && !tx_busy;
   assign ovr_set = rx_valid && rx_full && !rxd_rd;
   assign ovr_clr = con_wr && bus.wdata[CON_OVR];

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         tx_data   <= '0;
         overrun   <= 1'b0;
         rx_irq_en <= 1'b0;
         tx_irq_en <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (ld_data) tx_data <= tx_dout;
         if (ovr_set)      overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;
         if (con_wr) begin
            tx_irq_en <= bus.wdata[CON_TXIE];
            rx_irq_en <= bus.wdata[CON_RXIE];
         end
         irq <= (rx_irq_en && !rx_empty) || (tx_irq_en && tx_idle);
      end
   end

   logic [5:0] con_val;

   always_comb begin
      con_val              = '0;
      con_val[CON_RXNE]    = !rx_empty;
      con_val[CON_OVR]     = overrun;
      con_val[CON_TXFULL]  = tx_full;
      con_val[CON_TXIDLE]  = tx_idle;
      con_val[CON_RXIE]    = rx_irq_en;
      con_val[CON_TXIE]    = tx_irq_en;
   end

   always_comb begin
      bus.rdata = '0;
      if (hit_rxd && !rx_empty) bus.rdata = {24'b0, rx_dout};
      else if (hit_con)         bus.rdata = {26'b0, con_val};
   end

   logic unused_ok;
   assign unused_ok = ^{bus.wdata[31:8], bus.addr[1:0], rx_count, tx_count};

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge: register-level vector table plus
// hand-written sequences for FIFO edge cases, TX sequencing, irq and reset.
module tb_uart_mmio_bridge;
   import uart_mmio_pkg::*;

   localparam logic [31:0] BASE  = 32'h40000018;
   localparam logic [31:0] TXD_A = BASE;
   localparam logic [31:0] RXD_A = BASE + 32'h4;
   localparam logic [31:0] CON_A = BASE + 32'h8;

   logic       sysclk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       irq;
   tx_state_t  dbg_state;

   uart_mmio_bridge_if bus ();

   uart_mmio_bridge #(.RX_DEPTH(8), .TX_DEPTH(8), .BASE_ADDR(BASE)) dut (
      .sysclk    (sysclk),
      .reset_n   (reset_n),
      .bus       (bus),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_busy   (tx_busy),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .irq       (irq),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / sender model ----------------
   always #5 sysclk = ~sysclk;

   typedef enum logic [1:0] {BUSY_LOW, BUSY_HIGH, BUSY_MODEL} busy_mode_t;
   busy_mode_t busy_mode = BUSY_LOW;
   int         busy_cnt  = 0;

   // Modelled sender stays busy for 10 cycles after each accepted start.
   always @(posedge sysclk) begin
      if (tx_start)          busy_cnt <= 10;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_mode == BUSY_HIGH) || ((busy_mode == BUSY_MODEL) && (busy_cnt != 0));

   // ---------------- scoreboard ----------------
   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   bit         mon_en    = 1'b1;
   bit         gap6      = 1'b0;
   bit         have_prev = 1'b0;
   int         since_last = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks (enter and leave at posedge+1) ----------------
   task automatic bus_cycle(input logic rxv, input logic [7:0] rxd, input logic rd,
                            input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rv);
      bus.addr     = a;
      bus.MemRead  = rd;
      bus.MemWrite = wr;
      bus.wdata    = wd;
      rx_valid     = rxv;
      rx_data      = rxd;
      @(negedge sysclk);
      rv = bus.rdata;
      @(posedge sysclk);
      #1;
      bus.addr     = '0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.wdata    = '0;
      rx_valid     = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] v;
      bus_cycle(1'b0, 8'h0, 1'b0, 1'b1, a, d, v);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus_cycle(1'b0, 8'h0, 1'b1, 1'b0, a, 32'h0, v);
      check(name, v, exp);
   endtask

   task automatic rx_push(input logic [7:0] d);
      logic [31:0] v;
      bus_cycle(1'b1, d, 1'b0, 1'b0, 32'h0, 32'h0, v);
   endtask

   task automatic wait_tx_drained(input int budget);
      logic [31:0] v;
      bit          done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         bus_cycle(1'b0, 8'h0, 1'b1, 1'b0, CON_A, 32'h0, v);
         if (exp_q.size() == 0 && v[CON_TXIDLE]) done = 1'b1;
      end
      check("tx_drain_within_budget", 32'(done), 32'h1);
   endtask

   // ---------------- vector table ----------------
   typedef enum logic [1:0] {OP_RD, OP_WR, OP_RX} op_t;
   typedef struct {
      op_t         op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   function automatic vec_t mk(op_t o, logic [31:0] a, logic [31:0] d, logic [31:0] e);
      vec_t v;
      v.op = o; v.addr = a; v.data = d; v.exp = e;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] v;
      bit          found;

      bus.addr = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.wdata = '0;

      // TX start monitor: data order, never while busy, spacing.
      fork
         forever begin
            @(negedge sysclk);
            since_last++;
            if (mon_en && tx_start) begin
               check("start_while_busy", 32'(tx_busy), 32'h0);
               if (have_prev) begin
                  check("start_spacing_ge3", 32'(since_last >= 3), 32'h1);
                  if (gap6) check("timeout_gap", 32'(since_last), 32'd6);
               end
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_start: tx_data 0x%02h, expected no start", tx_data);
               end else begin
                  check("tx_data_at_start", 32'(tx_data), 32'(exp_q.pop_front()));
               end
               have_prev  = 1'b1;
               since_last = 0;
            end
         end
      join_none

      // ---- reset and reset state ----
      repeat (3) @(posedge sysclk);
      #1 reset_n = 1'b1;
      @(posedge sysclk); #1;
      check("rst_tx_start", 32'(tx_start), 32'h0);
      check("rst_tx_data", 32'(tx_data), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      rd_chk("rst_con", CON_A, 32'h08);

      // ---- register table, sender held busy so tx_idle stays 0 ----
      busy_mode = BUSY_HIGH;
      vecs.push_back(mk(OP_RD, CON_A, 0, 32'h00));
      vecs.push_back(mk(OP_RD, TXD_A, 0, 32'h00));
      vecs.push_back(mk(OP_RD, RXD_A, 0, 32'h00));
      for (int i = 0; i < 9; i++) vecs.push_back(mk(OP_RX, 0, 32'(i), 0));
      vecs.push_back(mk(OP_RD, CON_A, 0, 32'h03));
      vecs.push_back(mk(OP_RD, CON_A + 32'h3, 0, 32'h03));
      vecs.push_back(mk(OP_RD, BASE + 32'hC, 0, 32'h00));
      for (int i = 0; i < 8; i++) vecs.push_back(mk(OP_RD, RXD_A, 0, 32'(i)));
      vecs.push_back(mk(OP_RD, RXD_A, 0, 32'h00));
      vecs.push_back(mk(OP_RD, CON_A, 0, 32'h02));
      vecs.push_back(mk(OP_WR, CON_A, 32'h02, 0));
      vecs.push_back(mk(OP_RD, CON_A, 0, 32'h00));
      vecs.push_back(mk(OP_WR, CON_A, 32'h30, 0));
      vecs.push_back(mk(OP_RD, CON_A, 0, 32'h30));
      vecs.push_back(mk(OP_WR, CON_A, 32'h00, 0));
      vecs.push_back(mk(OP_RD, CON_A, 0, 32'h00));
      for (int i = 0; i < vecs.size(); i++) begin
         case (vecs[i].op)
            OP_RD: begin
               bus_cycle(1'b0, 8'h0, 1'b1, 1'b0, vecs[i].addr, 32'h0, v);
               check($sformatf("vec%0d_rd", i), v, vecs[i].exp);
            end
            OP_WR:   bus_cycle(1'b0, 8'h0, 1'b0, 1'b1, vecs[i].addr, vecs[i].data, v);
            default: bus_cycle(1'b1, vecs[i].data[7:0], 1'b0, 1'b0, 32'h0, 32'h0, v);
         endcase
      end

      // ---- rx irq: registered, one cycle behind the FIFO state ----
      wr(CON_A, 32'h10);
      rx_push(8'hA5);
      @(negedge sysclk); check("irq_push_edge", 32'(irq), 32'h0);
      @(posedge sysclk); #1;
      @(negedge sysclk); check("irq_after_push", 32'(irq), 32'h1);
      @(posedge sysclk); #1;
      rd_chk("irq_rxd", RXD_A, 32'hA5);
      @(negedge sysclk); check("irq_pop_edge", 32'(irq), 32'h1);
      @(posedge sysclk); #1;
      @(negedge sysclk); check("irq_after_pop", 32'(irq), 32'h0);
      @(posedge sysclk); #1;
      wr(CON_A, 32'h00);

      // ---- full RX: push+pop same cycle, then overrun beats clear ----
      for (int i = 0; i < 8; i++) rx_push(8'h10 + 8'(i));
      bus_cycle(1'b1, 8'h55, 1'b1, 1'b0, RXD_A, 32'h0, v);
      check("full_pushpop_head", v, 32'h10);
      rd_chk("full_pushpop_con", CON_A, 32'h01);
      bus_cycle(1'b1, 8'h66, 1'b0, 1'b1, CON_A, 32'h02, v);
      rd_chk("ovr_beats_clear_con", CON_A, 32'h03);
      for (int i = 1; i < 8; i++) rd_chk($sformatf("drain_rx%0d", i), RXD_A, 32'h10 + 32'(i));
      rd_chk("drain_rx_55", RXD_A, 32'h55);
      rd_chk("drain_rx_empty", RXD_A, 32'h00);
      wr(CON_A, 32'h02);
      rd_chk("ovr_cleared_con", CON_A, 32'h00);

      // ---- full TX while busy, then timeout-paced drain ----
      have_prev = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr(TXD_A, 32'hC0 + 32'(i));
         exp_q.push_back(8'hC0 + 8'(i));
      end
      wr(TXD_A, 32'h99);
      rd_chk("tx_full_con", CON_A, 32'h04);
      gap6      = 1'b1;
      busy_mode = BUSY_LOW;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge sysclk);
         if (dbg_state == LAUNCH) found = 1'b1;
      end
      check("launch_seen", 32'(found), 32'h1);
      bus.addr = TXD_A; bus.wdata = 32'h77; bus.MemWrite = 1'b1;
      exp_q.push_back(8'h77);
      @(posedge sysclk); #1;
      bus.MemWrite = 1'b0; bus.addr = '0; bus.wdata = '0;
      rd_chk("push_on_launch_full", CON_A, 32'h04);
      wait_tx_drained(200);
      gap6 = 1'b0;

      // ---- two bytes with a modelled 10-cycle busy sender ----
      busy_mode = BUSY_MODEL;
      have_prev = 1'b0;
      wr(TXD_A, 32'h41); exp_q.push_back(8'h41);
      wr(TXD_A, 32'h42); exp_q.push_back(8'h42);
      wait_tx_drained(100);
      repeat (5) @(posedge sysclk);
      #1;

      // ---- asynchronous reset with both FIFOs loaded ----
      mon_en    = 1'b0;
      busy_mode = BUSY_LOW;
      wr(TXD_A, 32'h01); wr(TXD_A, 32'h02); wr(TXD_A, 32'h03);
      rx_push(8'h11); rx_push(8'h22);
      wr(CON_A, 32'h30);
      repeat (2) @(posedge sysclk);
      @(negedge sysclk); check("pre_reset_irq", 32'(irq), 32'h1);
      #2;
      bus.addr = CON_A;
      reset_n  = 1'b0;
      #1;
      check("async_rst_con", bus.rdata, 32'h08);
      check("async_rst_irq", 32'(irq), 32'h0);
      check("async_rst_tx_data", 32'(tx_data), 32'h0);
      check("async_rst_tx_start", 32'(tx_start), 32'h0);
      check("async_rst_state", 32'(dbg_state), 32'(IDLE));
      bus.addr = RXD_A;
      #1;
      check("async_rst_rxd", bus.rdata, 32'h0);
      @(posedge sysclk); #1;
      reset_n  = 1'b1;
      bus.addr = '0;
      @(posedge sysclk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
